// File: rtl/avg_unpool_if.sv
// ---------------------------------------------------------------------------
// avg_unpool_if
//   Handshake and data bundle for the average-unpool expansion stage.
//
//   Signals (direction seen from the slave / the expansion block):
//     start      in   begin an expansion (honoured only while idle)
//     input_fm   in   IN_W x IN_W signed source map, raster order
//     busy       out  expansion in progress
//     done       out  expansion finished, held until the next accepted start
//     out_valid  out  one-cycle strobe per written output pixel
//     out_addr   out  raster index of the pixel being written
//     out_data   out  value being written
//     output_fm  out  OUT_W x OUT_W signed result map, raster order
//
//   master: the producer/consumer that drives start and input_fm.
//   slave : avg_unpool_layer.
// ---------------------------------------------------------------------------
interface avg_unpool_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 6,
    parameter int DW    = 32
);
    logic                                 start;
    logic signed [DW-1:0]                 input_fm  [0:IN_W*IN_W-1];
    logic                                 busy;
    logic                                 done;
    logic                                 out_valid;
    logic [$clog2(OUT_W*OUT_W)-1:0]       out_addr;
    logic signed [DW-1:0]                 out_data;
    logic signed [DW-1:0]                 output_fm [0:OUT_W*OUT_W-1];

    modport master (
        output start, input_fm,
        input  busy, done, out_valid, out_addr, out_data, output_fm
    );

    modport slave (
        input  start, input_fm,
        output busy, done, out_valid, out_addr, out_data, output_fm
    );
endinterface

// File: rtl/avg_unpool_layer.sv
// ---------------------------------------------------------------------------
// avg_unpool_layer
//   Inverse of the 2x2 stride-2 pooling stage. Latches an IN_W x IN_W signed
//   map on an accepted start, then writes the 2*IN_W x 2*IN_W expansion one
//   pixel per cycle in raster order. Every source value fills its 2x2 block.
//
//   Optional feature (compile-time macro AVG_UNPOOL_BACKPROP_EN):
//     defined   : each written value is source >>> 2 (average-pool gradient
//                 spread over its window, floor toward -inf)
//     undefined : each written value is the source value (pure replication)
//   Timing and write order are identical in both builds.
//
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   asynchronous active-high reset
//     bus   avg_unpool_if.slave (start/input_fm in; busy, done, out_valid,
//           out_addr, out_data, output_fm out -- all registered)
// ---------------------------------------------------------------------------
module avg_unpool_layer #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 6,
    parameter int DW    = 32
) (
    input  logic        clk,
    input  logic        rst,
    avg_unpool_if.slave bus
);
    localparam int N_IN  = IN_W * IN_W;
    localparam int N_OUT = OUT_W * OUT_W;
    localparam int CW    = $clog2(OUT_W);
    localparam int SW    = $clog2(N_IN);
    localparam int AW    = $clog2(N_OUT);

    typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        row_q, col_q;
    logic signed [DW-1:0] buf_q [0:N_IN-1];
    logic signed [DW-1:0] fm_q  [0:N_OUT-1];
    logic                 busy_q, done_q, valid_q;
    logic [AW-1:0]        addr_q;
    logic signed [DW-1:0] data_q;

    // Decoded controls for the current cycle.
    logic                 accept;
    logic                 col_last;
    logic                 last_px;
    logic [SW-1:0]        src;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] pix;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = EXPAND;
            EXPAND:  if (last_px) state_d = FINISH;
            FINISH:               state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // ---------------- output / datapath decode ----------------
    always_comb begin
        accept   = (state_q == IDLE) && bus.start;
        col_last = (col_q == CW'(OUT_W - 1));
        last_px  = col_last && (row_q == CW'(OUT_W - 1));
        // Each 2x2 output block maps back to one source pixel.
        src      = SW'(row_q >> 1) * SW'(IN_W) + SW'(col_q >> 1);
        addr     = AW'(row_q) * AW'(OUT_W) + AW'(col_q);
`ifdef AVG_UNPOOL_BACKPROP_EN
        pix      = buf_q[src] >>> 2;
`else
        pix      = buf_q[src];
`endif
    end

    // ---------------- registered outputs ----------------
    // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            // NOTE: the source buffer and result map are visible state, so they are reset explicitly.
            for (int i = 0; i < N_IN; i++)  buf_q[i] <= '0;
            for (int i = 0; i < N_OUT; i++) fm_q[i]  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < N_IN; i++) buf_q[i] <= bus.input_fm[i];
                        row_q  <= '0;
                        col_q  <= '0;
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                EXPAND: begin
                    fm_q[addr] <= pix;
                    data_q     <= pix;
                    addr_q     <= addr;
                    valid_q    <= 1'b1;
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= row_q + CW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                FINISH: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = valid_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_data  = data_q;
    assign bus.output_fm = fm_q;

endmodule

// File: doc/avg_unpool_layer.md
# avg_unpool_layer

Inverse of the 2x2 stride-2 pooling stage in the CNN core. Latches a 3x3 signed feature map and expands it to 6x6 in raster order, one output pixel per cycle. Each source value is replicated into its 2x2 block (nearest-neighbour upsample), or divided by 4 when backprop scaling is compiled in. Results go to a parallel 36-entry output array and a per-pixel write strobe for streaming consumers.

## Interface
- `IN_W`, default 3: input feature map width and height.
- `OUT_W`, default 6: output width and height; always `2*IN_W`.
- `DW`, default 32: signed data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin an expansion; sampled only in IDLE.
- `input_fm[0:8]`  in  signed `DW` each  3x3 source map, raster order.
- `busy`  out  1  high while an expansion is in progress.
- `done`  out  1  high after completion; held until the next accepted start.
- `out_valid`  out  1  one-cycle strobe per written pixel.
- `out_addr`  out  6  raster index of the pixel being written (0..35).
- `out_data`  out  signed `DW`  value being written.
- `output_fm[0:35]`  out  signed `DW` each  6x6 result map, raster order.

## Operation
- States: IDLE, EXPAND, FINISH.
- **IDLE**
  - On `start=1`: copy all 9 `input_fm` words into an internal buffer.
  - Clear `row`/`col` (3-bit each) and `done`; set `busy`; go to EXPAND.
  - `input_fm` is don't-care after the accepting edge.
- **EXPAND** (every edge):
  - src = `(row>>1)*IN_W + (col>>1)`; addr = `row*OUT_W + col`.
  - Write `output_fm[addr]` and `out_data` = f(buf[src]); `out_addr` = addr; `out_valid` = 1.
  - Advance col; on `col == OUT_W-1`, wrap col to 0 and increment row.
  - On `row == OUT_W-1 && col == OUT_W-1`, go to FINISH.
- **FINISH**: `out_valid` = 0, `busy` = 0, `done` = 1; go to IDLE.
- f is identity by default (see Configuration).
- `start` outside IDLE is ignored, with no queuing.
- `output_fm` entries not yet rewritten keep their previous values during EXPAND.
- `out_valid` is 0 in every state except the edge-registered EXPAND writes.

## Timing
- `start` sampled high in IDLE at edge k:
  - `busy` = 1 from edge k.
  - Writes at edges k+1 … k+36; `out_addr` 0 at k+1, 35 at k+36.
  - At edge k+37: `done` = 1, `busy` = 0, `out_valid` = 0.
- Back-to-back: a new `start` can be accepted at edge k+38 at the earliest; `done` clears at that edge.
- Reset values: `busy` = 0, `done` = 0, `out_valid` = 0, `out_addr` = 0, `out_data` = 0, all `output_fm` = 0, internal buffer = 0, state IDLE.
- Reset mid-EXPAND: immediate return to the reset values. No partial `done`; the aborted run is not resumed.
- `start` held high continuously: one run per IDLE visit. A new run starts at k+38 if `start` is still high.
- All outputs are registered; there is no combinational path from `start` or `input_fm` to any output.

## Configuration
- Macro: `AVG_UNPOOL_BACKPROP_EN`.
  - **Defined**: f(x) = `x >>> 2` (arithmetic shift, floor toward −inf). Distributes an average-pool gradient across its 2x2 window. Sign is preserved; no saturation is needed.
  - **Undefined**: f(x) = x (pure replication). Latency, handshake and write order are identical in both builds.

## Test plan
- **Reset**: assert `rst` asynchronously mid-cycle → all outputs read 0 immediately, without waiting for `clk`.
- **Replication** (macro off): `input_fm` = {1..9}, pulse `start` → 36 `out_valid` strobes at k+1..k+36.
  - Expected: `output_fm[0]`=1, `[1]`=1, `[6]`=1, `[7]`=1, `[2]`=2, `[35]`=9; `done` at k+37.
- **Backprop** (macro on): `input_fm[0]`=7, `[1]`=−5, `[8]`=−4.
  - Expected: `output_fm[0]`=1, `[7]`=1, `[2]`=−2, `[3]`=−2, `[35]`=−1.
- **Input change**: change `input_fm` at k+1 and hold `start` low → the output reflects only the values latched at k.
- **Busy overlap**: pulse `start` at k+10 while busy → ignored; exactly 36 strobes. A second `start` at k+38 is accepted and `done` drops at k+38.
- **Mid-run reset**: assert `rst` at k+20 → `busy`/`done`/`output_fm` = 0. A fresh `start` then completes a full 36-write run.
